rom_msg_sequencer: RTL and testbench
====================================

// Module: rom_msg_sequencer
// PURPOSE
//   Sequencer for the 16x8 character ROM (4-bit addr in, 8-bit ASCII data out, combinational).
//   On start, walks ROM addresses 0..MSG_LEN-1 and presents each character on a valid/ready
//   stream with optional inter-character pacing. Supports one-shot or looping playback and abort.
//   Sits between the ROM and a character sink (display driver / serial TX).
// PARAMETERS
//   ADDR_W      4    ROM address width
//   DATA_W      8    ROM data / character width
//   MSG_LEN     12   characters per message, 1..2**ADDR_W (message = "ENGINEERING ")
//   GAP_CYCLES  0    idle cycles inserted after each accepted character, 0..255
// PORTS
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous reset, active-high
//   start       in   1       begin playback; sampled only in IDLE
//   loop_en     in   1       latched with start: 1 = wrap to addr 0 after last char
//   abort       in   1       terminate playback; return to IDLE
//   rom_addr    out  ADDR_W  address to ROM (driven from index register)
//   rom_data    in   DATA_W  ROM read data, valid same cycle as rom_addr
//   char_out    out  DATA_W  registered character
//   char_valid  out  1       char_out valid
//   char_ready  in   1       sink accepts char_out when char_valid && char_ready
//   busy        out  1       high in any state except IDLE
//   done        out  1       one-cycle pulse after last char of a one-shot message accepted
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, idx=0, rom_addr=0, char_out=0, char_valid=0,
//     busy=0, done=0, gap counter=0, latched loop=0. Effective immediately on assertion.
//   rom_addr = idx at all times. States: IDLE, FETCH, SEND, GAP, DONE.
//   IDLE : start=1 -> FETCH, idx<=0, loop_q<=loop_en. Else stay.
//   FETCH: char_out<=rom_data -> SEND (one cycle).
//   SEND : char_valid=1; char_out stable until accepted. On accept (valid&&ready):
//     - idx==MSG_LEN-1 && !loop_q -> DONE.
//     - idx==MSG_LEN-1 &&  loop_q -> idx<=0 (wrap).
//     - otherwise idx<=idx+1.
//     - not DONE: GAP_CYCLES==0 -> FETCH; else GAP with cnt<=GAP_CYCLES-1.
//   GAP  : cnt==0 -> FETCH, else cnt<=cnt-1. Exactly GAP_CYCLES cycles spent in GAP.
//   DONE : done=1 for this one cycle -> IDLE.
//   Latency: start high at edge N -> FETCH in cycle N+1, char_valid first high cycle N+2.
//   Throughput, ready held high: one char every 2+GAP_CYCLES cycles.
//   abort: highest priority after rst, any non-IDLE state -> IDLE next edge; char_valid drops,
//     done NOT pulsed, idx<=0. abort in IDLE ignored; abort && start in IDLE -> stay IDLE.
//   start while busy ignored; loop_en changes mid-message ignored (loop_q used).
//   Looping playback ends only on abort or rst.
//   idx counts in ADDR_W bits; never exceeds MSG_LEN-1. MSG_LEN=2**ADDR_W wraps naturally.
//   char_valid never depends combinationally on char_ready.
// TESTING
//   1. rst, start pulse, ready=1, GAP=0 -> 12 chars 45 4E 47 49 4E 45 45 52 49 4E 47 20,
//      char_valid first at cycle 2, one char per 2 cycles, done pulse 1 cycle after 0x20 accepted.
//   2. Backpressure: ready low 5 cycles during 3rd char -> char_out holds 0x47, valid held, no
//      skip/duplicate; sequence completes identically.
//   3. loop_en=1 at start, then deassert -> after 0x20 next char 0x45 (addr 0), no done; abort
//      during 2nd pass -> IDLE next cycle, busy=0, no done.
//   4. GAP_CYCLES=3, ready=1 -> accepted chars spaced exactly 5 cycles apart.
//   5. start pulsed while busy -> ignored, sequence uninterrupted; start&&abort in IDLE -> no start.
//   6. rst asserted mid-SEND (asynchronously, between edges) -> all outputs 0 immediately;
//      after release, new start replays from 0x45.

Source files
------------

// File: rtl/rom_msg_sequencer_if.sv
// Character-stream bundle between the message sequencer, its ROM and the character sink.
// Latency: none (wires only).
// Backpressure: char_valid/char_ready handshake; the master holds char_out until accepted.
// Ports (master = sequencer side):
//   in : start, loop_en, abort, rom_data, char_ready
//   out: rom_addr, char_out, char_valid, busy, done
interface rom_msg_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              loop_en;
    logic              abort;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] char_out;
    logic              char_valid;
    logic              char_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, loop_en, abort, rom_data, char_ready,
        output rom_addr, char_out, char_valid, busy, done
    );

    modport slave (
        output start, loop_en, abort, rom_data, char_ready,
        input  rom_addr, char_out, char_valid, busy, done
    );
endinterface

// File: rtl/rom_msg_sequencer.sv
// Walks ROM addresses 0..MSG_LEN-1 and streams each character, one-shot or looping, abortable.
// Latency: start sampled at edge N -> FETCH in cycle N+1, first char_valid in cycle N+2;
//          one char every 2+GAP_CYCLES cycles with the sink always ready.
// Backpressure: char_out/char_valid held in SEND until char_ready; valid is a pure state decode.
// Ports: clk, rst (async, active-high); bus = rom_msg_sequencer_if.master
//   (start/loop_en/abort control, rom_addr/rom_data ROM port, char_out/char_valid/char_ready
//    stream, busy/done status).
module rom_msg_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int MSG_LEN    = 12,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    rom_msg_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
    // Counter is loaded with GAP_CYCLES-1 so that GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [7:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam state_t            AFTER_SEND = (GAP_CYCLES == 0) ? FETCH : GAP;

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [7:0]        cnt, cnt_n;
    logic [DATA_W-1:0] char_q, char_n;
    logic              loop_q, loop_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            char_q <= '0;
            loop_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            char_q <= char_n;
            loop_q <= loop_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        char_n  = char_q;
        loop_n  = loop_q;

        case (state)
            IDLE: begin
                // abort alongside start in IDLE suppresses the start.
                if (bus.start && !bus.abort) begin
                    state_n = FETCH;
                    idx_n   = '0;
                    loop_n  = bus.loop_en;
                end
            end
            FETCH: begin
                char_n  = bus.rom_data;
                state_n = SEND;
            end
            SEND: begin
                if (bus.char_ready) begin
                    if (idx == LAST_IDX && !loop_q) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
                        state_n = AFTER_SEND;
                        cnt_n   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_n = FETCH;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // abort overrides everything except reset, but only once playback is running.
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            idx_n   = '0;
        end
    end

    assign bus.rom_addr   = idx;
    assign bus.char_out   = char_q;
    assign bus.char_valid = (state == SEND);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_rom_msg_sequencer.sv
module tb_rom_msg_sequencer;

    localparam int MSG_LEN = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, loop_en = 1'b0, abort = 1'b0, ready = 1'b0;

    logic [7:0] rom [16];
    logic [7:0] exp_msg [MSG_LEN];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_msg_sequencer_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
    rom_msg_sequencer_if #(.ADDR_W(4), .DATA_W(8)) b3 ();

    assign b0.start = start;   assign b3.start = start;
    assign b0.loop_en = loop_en; assign b3.loop_en = loop_en;
    assign b0.abort = abort;   assign b3.abort = abort;
    assign b0.char_ready = ready; assign b3.char_ready = ready;
    assign b0.rom_data = rom[b0.rom_addr];
    assign b3.rom_data = rom[b3.rom_addr];

    rom_msg_sequencer #(.ADDR_W(4), .DATA_W(8), .MSG_LEN(MSG_LEN), .GAP_CYCLES(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    rom_msg_sequencer #(.ADDR_W(4), .DATA_W(8), .MSG_LEN(MSG_LEN), .GAP_CYCLES(3)) dut_gap (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit sel, output logic v, output logic [7:0] c,
                          output logic d, output logic b, output logic [3:0] a);
        if (sel) begin
            v = b3.char_valid; c = b3.char_out; d = b3.done; b = b3.busy; a = b3.rom_addr;
        end else begin
            v = b0.char_valid; c = b0.char_out; d = b0.done; b = b0.busy; a = b0.rom_addr;
        end
    endtask

    // Plays one message on the selected instance and checks every accepted character
    // against the reference message, the handshake hold rule, timing and done/busy.
    // mode: 0 = ready always high, 1 = random ready, 2 = stall 3rd char for 5 cycles.
    task automatic play(input bit sel, input bit lp, input int mode, input int n_target,
                        input int poke_at, input bit abort_end);
        int gap = sel ? 3 : 0;
        int n = 0, t = 0, last_acc = -10, stall = 0;
        bit fin = 0, first_seen = 0, prev_stall = 0, poked = 0, r;
        logic [7:0] held = 8'h00;
        logic v, d, b;
        logic [7:0] c;
        logic [3:0] a;

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b1;
        loop_en = lp;
        @(negedge clk);
        start = 1'b0;
        loop_en = ~lp;
        while (!fin && t < 600) begin
            sample(sel, v, c, d, b, a);
            if (prev_stall) begin
                check("hold_valid", 32'(v), 32'd1);
                check("hold_char", 32'(c), 32'(held));
            end
            if (v && !first_seen) begin
                first_seen = 1;
                check("first_valid_cycle", t, 1);
            end
            check("addr_in_range", 32'(a < 4'(MSG_LEN)), 32'd1);
            check("done", 32'(d), 32'(!lp && n == MSG_LEN && t == last_acc + 1));
            if (!lp && n == MSG_LEN && t == last_acc + 2) begin
                check("busy_after_done", 32'(b), 32'd0);
                fin = 1;
            end
            if (mode == 0)      r = 1;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else                r = !(v && n == 2 && stall < 5);
            if (v && !r && mode == 2) stall++;
            if (v && r) begin
                check("char", 32'(c), 32'(exp_msg[n % MSG_LEN]));
                check("rom_addr", 32'(a), n % MSG_LEN);
                if (mode == 0 && n > 0) check("spacing", t - last_acc, 2 + gap);
                last_acc = t;
                n++;
            end
            prev_stall = v && !r;
            held = c;
            ready = r;
            if (n == poke_at && !poked && !fin) begin
                start = 1'b1;
                loop_en = 1'b1;
                poked = 1;
            end else begin
                start = 1'b0;
                loop_en = ~lp;
            end
            if (lp && n == n_target) fin = 1;
            t++;
            @(negedge clk);
        end
        start = 1'b0;
        check("play_finished", 32'(fin), 32'd1);
        if (mode == 2) check("stall_cycles", stall, 5);
        if (abort_end) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            for (int k = 0; k < 3; k++) begin
                sample(sel, v, c, d, b, a);
                check("abort_busy", 32'(b), 32'd0);
                check("abort_valid", 32'(v), 32'd0);
                check("abort_done", 32'(d), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin : main
        string s;
        bit found;
        logic v, d, b;
        logic [7:0] c;
        logic [3:0] a;

        s = "ENGINEERING ";
        for (int i = 0; i < 16; i++) rom[i] = (i < MSG_LEN) ? s[i] : 8'hFF;
        exp_msg = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45,
                    8'h45, 8'h52, 8'h49, 8'h4E, 8'h47, 8'h20};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(b0.char_valid), 32'd0);
        check("rst_char", 32'(b0.char_out), 32'd0);
        check("rst_busy", 32'(b0.busy), 32'd0);
        check("rst_done", 32'(b0.done), 32'd0);
        check("rst_addr", 32'(b0.rom_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // One-shot, ready high
        play(0, 0, 0, MSG_LEN, -1, 0);
        // Backpressure on the third character
        play(0, 0, 2, MSG_LEN, -1, 0);
        // Random ready with start poked while busy
        play(0, 0, 1, MSG_LEN, 5, 0);
        // Looping, loop_en dropped after start, abort during second pass
        play(0, 1, 1, MSG_LEN + 4, -1, 1);
        // Inter-character gap of 3
        play(1, 0, 0, MSG_LEN, -1, 0);
        // Looping on the gapped instance with random ready, then abort
        play(1, 1, 1, MSG_LEN + 2, -1, 1);

        // start together with abort in IDLE must not start
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(b0.busy), 32'd0);
        @(negedge clk);
        check("start_abort_busy2", 32'(b0.busy), 32'd0);
        check("start_abort_valid", 32'(b0.char_valid), 32'd0);

        // Asynchronous reset while presenting the third character
        start = 1'b1;
        loop_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            sample(0, v, c, d, b, a);
            if (v && c == exp_msg[2]) begin
                found = 1;
                ready = 1'b0;
            end else begin
                ready = 1'b1;
                @(negedge clk);
            end
        end
        check("third_char_reached", 32'(found), 32'd1);
        check("third_char_addr", 32'(b0.rom_addr), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(b0.char_valid), 32'd0);
        check("arst_char", 32'(b0.char_out), 32'd0);
        check("arst_busy", 32'(b0.busy), 32'd0);
        check("arst_done", 32'(b0.done), 32'd0);
        check("arst_addr", 32'(b0.rom_addr), 32'd0);
        check("arst_gap_busy", 32'(b3.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        play(0, 0, 0, MSG_LEN, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
